tcp_tx_stream_gen: RTL and testbench

// Application-side TCP transmit driver sitting directly upstream of network_top's
// s_axis_tx_metadata / s_axis_tx_data ports and consuming its m_axis_tx_status.
// It sends a run of fixed-length packets on one open session:
// - requests space with a metadata word;
// - waits for the stack's status reply;
// - on success streams the payload, on error backs off and retries.
// It produces the byte and retry counts the perf ILA needs.

---
 rtl/tcp_tx_stream_gen.sv | 143 ++++++++++++++
 tb/tb_tcp_tx_stream_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_stream_gen.sv
// TCP transmit driver: requests tx space per packet, waits for the stack's
// status, then streams a fixed-length payload of running beat indices.
module tcp_tx_stream_gen #(
  parameter int DATA_W    = 512,
  parameter int RETRY_GAP = 64
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [15:0]         cfg_session,
  input  logic [15:0]         cfg_pkt_len,
  input  logic [31:0]         cfg_num_pkts,
  output logic                m_tx_meta_valid,
  input  logic                m_tx_meta_ready,
  output logic [31:0]         m_tx_meta_data,
  input  logic                s_tx_sts_valid,
  output logic                s_tx_sts_ready,
  input  logic [63:0]         s_tx_sts_data,
  output logic                m_tx_data_valid,
  input  logic                m_tx_data_ready,
  output logic [DATA_W-1:0]   m_tx_data_data,
  output logic [DATA_W/8-1:0] m_tx_data_keep,
  output logic                m_tx_data_last,
  output logic                busy,
  output logic                done,
  output logic [63:0]         sent_bytes,
  output logic [31:0]         retry_cnt
);

  localparam int BPB = DATA_W / 8;
  localparam int LOG = $clog2(BPB);
  localparam int GW  = $clog2(RETRY_GAP + 1);
  localparam logic [LOG:0]  BPB_L    = (LOG+1)'(BPB);
  localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_META, S_STS, S_DATA, S_GAP, S_DONE
  } state_e;

  state_e        state_q;
  logic [15:0]   sess_q;
  logic [15:0]   len_q;
  logic [31:0]   pkts_q;
  logic [15:0]   beats_q;
  logic [63:0]   idx_q;
  logic [63:0]   sent_q;
  logic [31:0]   retry_q;
  logic [GW-1:0] gap_q;

  logic [16:0]    len_ext;
  logic [15:0]    beats_init;
  logic [LOG-1:0] tail;
  logic [LOG:0]   tail_bytes;
  logic [LOG:0]   beat_bytes;
  logic           is_last;
  logic           sts_match;
  logic [2:0]     sts_err;
  logic [BPB-1:0] ones;
  logic [44:0]    sts_unused;

  assign len_ext    = {1'b0, len_q} + 17'(BPB - 1);
  assign beats_init = 16'(len_ext >> LOG);
  assign tail       = len_q[LOG-1:0];
  assign tail_bytes = (tail == '0) ? BPB_L : {1'b0, tail};
  assign is_last    = (beats_q == 16'd1);
  assign beat_bytes = is_last ? tail_bytes : BPB_L;
  assign sts_match  = (s_tx_sts_data[15:0] == sess_q);
  assign sts_err    = s_tx_sts_data[63:61];
  assign sts_unused = s_tx_sts_data[60:16];
  assign ones       = '1;

  assign m_tx_meta_valid = (state_q == S_META);
  assign m_tx_meta_data  = {len_q, sess_q};
  assign s_tx_sts_ready  = (state_q == S_STS);
  assign m_tx_data_valid = (state_q == S_DATA);
  assign m_tx_data_data  = {(DATA_W/64){idx_q}};
  assign m_tx_data_last  = is_last;
  assign m_tx_data_keep  = is_last ? (ones >> (BPB_L - tail_bytes)) : ones;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign sent_bytes      = sent_q;
  assign retry_cnt       = retry_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      sess_q  <= '0;
      len_q   <= '0;
      pkts_q  <= '0;
      beats_q <= '0;
      idx_q   <= '0;
      sent_q  <= '0;
      retry_q <= '0;
      gap_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sess_q  <= cfg_session;
            len_q   <= cfg_pkt_len;
            pkts_q  <= cfg_num_pkts;
            sent_q  <= '0;
            retry_q <= '0;
            state_q <= (cfg_num_pkts == '0) ? S_DONE : S_META;
          end
        end
        S_META: begin
          if (m_tx_meta_ready) state_q <= S_STS;
        end
        S_STS: begin
          // statuses for other sessions are drained and dropped
          if (s_tx_sts_valid && sts_match) begin
            if (sts_err == 3'd0) begin
              beats_q <= beats_init;
              state_q <= S_DATA;
            end else begin
              if (retry_q != '1) retry_q <= retry_q + 32'd1;
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end
        end
        S_DATA: begin
          if (m_tx_data_ready) begin
            idx_q   <= idx_q + 64'd1;
            sent_q  <= sent_q + 64'(beat_bytes);
            beats_q <= beats_q - 16'd1;
            if (is_last) begin
              pkts_q  <= pkts_q - 32'd1;
              state_q <= (pkts_q == 32'd1) ? S_DONE : S_META;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_META;
          else gap_q <= gap_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_stream_gen.sv
// Random-backpressure bench for tcp_tx_stream_gen with a packet-level
// stack model (status queue, beat scoreboard, byte and retry totals).
module tb_tcp_tx_stream_gen;

  localparam int DW  = 512;
  localparam int BPB = DW / 8;
  localparam int GAP = 64;

  logic           aclk;
  logic           aresetn;
  logic           start;
  logic [15:0]    cfg_session;
  logic [15:0]    cfg_pkt_len;
  logic [31:0]    cfg_num_pkts;
  logic           m_tx_meta_valid;
  logic           m_tx_meta_ready;
  logic [31:0]    m_tx_meta_data;
  logic           s_tx_sts_valid;
  logic           s_tx_sts_ready;
  logic [63:0]    s_tx_sts_data;
  logic           m_tx_data_valid;
  logic           m_tx_data_ready;
  logic [DW-1:0]  m_tx_data_data;
  logic [BPB-1:0] m_tx_data_keep;
  logic           m_tx_data_last;
  logic           busy;
  logic           done;
  logic [63:0]    sent_bytes;
  logic [31:0]    retry_cnt;

  tcp_tx_stream_gen #(.DATA_W(DW), .RETRY_GAP(GAP)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start           (start),
    .cfg_session     (cfg_session),
    .cfg_pkt_len     (cfg_pkt_len),
    .cfg_num_pkts    (cfg_num_pkts),
    .m_tx_meta_valid (m_tx_meta_valid),
    .m_tx_meta_ready (m_tx_meta_ready),
    .m_tx_meta_data  (m_tx_meta_data),
    .s_tx_sts_valid  (s_tx_sts_valid),
    .s_tx_sts_ready  (s_tx_sts_ready),
    .s_tx_sts_data   (s_tx_sts_data),
    .m_tx_data_valid (m_tx_data_valid),
    .m_tx_data_ready (m_tx_data_ready),
    .m_tx_data_data  (m_tx_data_data),
    .m_tx_data_keep  (m_tx_data_keep),
    .m_tx_data_last  (m_tx_data_last),
    .busy            (busy),
    .done            (done),
    .sent_bytes      (sent_bytes),
    .retry_cnt       (retry_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int nchk;
  int npass;
  longint unsigned exp_idx;
  logic [63:0] sq[$];

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [511:0] repl(input longint unsigned v);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < DW/64; i++) r[i*64 +: 64] = v;
    return r;
  endfunction

  function automatic logic [63:0] mk_keep(input int nb);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < nb; i++) k[i] = 1'b1;
    return k;
  endfunction

  task automatic run(input logic [15:0] sess, input logic [15:0] len,
                     input int n, input int errs, input bit mism,
                     input int pm, input int pd, input bit poke,
                     input int abort_at);
    int cyc, metas, beats, j, pk, err_left, err_cyc, rem, nb;
    longint unsigned exp_sent;
    logic [31:0] exp_retry;
    bit fin, gap_pend, prev_nl, meta_next, pm_st, pd_st, lst;
    logic [31:0]  p_m;
    logic [511:0] p_d;
    logic [64:0]  p_kl;
    logic [63:0]  s;
    cyc = 0; metas = 0; beats = 0; j = 0; pk = 0; err_cyc = 0;
    err_left = errs; exp_sent = 0; exp_retry = '0;
    fin = 0; gap_pend = 0; prev_nl = 0; meta_next = 0;
    pm_st = 0; pd_st = 0; p_m = '0; p_d = '0; p_kl = '0;
    sq.delete();
    cfg_session = sess; cfg_pkt_len = len; cfg_num_pkts = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < 20000) begin
      if (pk >= n && done) begin
        fin = 1;
      end else begin
        start = 1'b0;
        if (poke && cyc == 1) begin
          chk("poke_busy", busy, 1);
          start = 1'b1;
          cfg_session = ~sess;
          cfg_pkt_len = len + 16'd7;
          cfg_num_pkts = n + 5;
        end
        if (pm_st) chk("meta_hold", {m_tx_meta_valid, m_tx_meta_data}, {1'b1, p_m});
        if (pd_st) begin
          chk("data_hold_v", m_tx_data_valid, 1);
          chk("data_hold_d", m_tx_data_data, p_d);
          chk("data_hold_kl", {m_tx_data_last, m_tx_data_keep}, p_kl);
        end
        if (meta_next) chk("meta_after_last", m_tx_meta_valid, 1);
        if (prev_nl) chk("no_bubble", m_tx_data_valid, 1);
        if (gap_pend && m_tx_meta_valid) begin
          chk("gap_len", cyc - err_cyc, GAP + 1);
          gap_pend = 0;
        end
        meta_next = 0;
        prev_nl = 0;
        m_tx_meta_ready = ($urandom % 100) < pm;
        m_tx_data_ready = ($urandom % 100) < pd;
        s_tx_sts_valid = sq.size() > 0;
        s_tx_sts_data = (sq.size() > 0) ? sq[0] : 64'd0;
        if (m_tx_meta_valid && m_tx_meta_ready) begin
          chk("meta_word", m_tx_meta_data, {len, sess});
          metas++;
          if (mism) sq.push_back({32'd0, len, sess ^ 16'h0001});
          if (err_left > 0) begin
            sq.push_back({3'b001, 29'd0, len, sess});
            err_left--;
          end else begin
            sq.push_back({32'd0, len, sess});
          end
        end
        if (s_tx_sts_valid && s_tx_sts_ready) begin
          s = sq.pop_front();
          if (s[15:0] == sess && s[63:61] != 3'd0) begin
            if (exp_retry != '1) exp_retry++;
            err_cyc = cyc;
            gap_pend = 1;
          end
        end
        if (m_tx_data_valid && m_tx_data_ready) begin
          rem = int'(len) - j * BPB;
          nb  = (rem >= BPB) ? BPB : rem;
          lst = (rem <= BPB);
          chk("beat_data", m_tx_data_data, repl(exp_idx));
          chk("beat_keep", {m_tx_data_last, m_tx_data_keep}, {lst, mk_keep(nb)});
          exp_idx++;
          exp_sent += longint'(nb);
          j++;
          beats++;
          prev_nl = !lst;
          if (lst) begin
            j = 0;
            pk++;
            meta_next = (pk < n);
          end
        end
        pm_st = m_tx_meta_valid && !m_tx_meta_ready;
        pd_st = m_tx_data_valid && !m_tx_data_ready;
        p_m   = m_tx_meta_data;
        p_d   = m_tx_data_data;
        p_kl  = {m_tx_data_last, m_tx_data_keep};
        if (abort_at > 0 && beats == abort_at) begin
          tick();
          aresetn = 1'b0;
          #1;
          chk("rst_valids", {m_tx_meta_valid, s_tx_sts_ready, m_tx_data_valid}, 0);
          chk("rst_sent", sent_bytes, 0);
          chk("rst_retry", retry_cnt, 0);
          chk("rst_busy", busy, 0);
          m_tx_meta_ready = 0; m_tx_data_ready = 0; s_tx_sts_valid = 0;
          exp_idx = 0;
          tick();
          aresetn = 1'b1;
          tick();
          chk("rst_idle", {busy, done, m_tx_meta_valid}, 0);
          return;
        end
        tick();
        cyc++;
      end
    end
    chk("finished", fin, 1);
    chk("done", done, 1);
    chk("idle_busy", busy, 0);
    chk("sent_bytes", sent_bytes, exp_sent);
    chk("retry_cnt", retry_cnt, exp_retry);
    chk("meta_count", metas, n + errs);
    chk("sts_drained", sq.size(), 0);
    m_tx_meta_ready = 0; m_tx_data_ready = 0; s_tx_sts_valid = 0;
  endtask

  initial begin
    nchk = 0; npass = 0; exp_idx = 0;
    aresetn = 1'b0; start = 1'b0;
    cfg_session = '0; cfg_pkt_len = '0; cfg_num_pkts = '0;
    m_tx_meta_ready = 0; m_tx_data_ready = 0;
    s_tx_sts_valid = 0; s_tx_sts_data = '0;
    tick();
    tick();
    chk("rst_valids0", {m_tx_meta_valid, s_tx_sts_ready, m_tx_data_valid}, 0);
    chk("rst_status0", {busy, done}, 0);
    chk("rst_counters0", {sent_bytes, retry_cnt}, 0);
    aresetn = 1'b1;
    tick();
    chk("idle_after_rst", {busy, done, m_tx_meta_valid}, 0);

    cfg_session = 16'h0009; cfg_pkt_len = 16'd64; cfg_num_pkts = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_pkts_done", {done, busy, m_tx_meta_valid}, 3'b100);
    tick();
    chk("zero_pkts_nometa", m_tx_meta_valid, 0);

    run(16'h1234, 16'd1024, 4, 0, 0, 100, 100, 0, 0);
    run(16'h0042, 16'd100, 3, 0, 0, 100, 100, 0, 0);
    run(16'hBEEF, 16'd200, 2, 1, 0, 100, 100, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run(16'($urandom), 16'($urandom_range(1, 3000)),
          int'($urandom_range(1, 4)), int'($urandom_range(0, 1)),
          bit'(i % 2), 50, 50, (i == 1), 0);
    end
    run(16'h0005, 16'd1024, 1, 0, 0, 100, 100, 0, 5);
    run(16'h0777, 16'd130, 2, 0, 1, 70, 60, 0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
